// File: rtl/wb_pipe_stage.sv
// Handshaked pipeline register between the MEM and WB stages.
// It carries ctrl/rd/data, supports flush, and has an optional skid entry that gives a registered o_ready.
module wb_pipe_stage #(
  parameter int DATA_W       = 32,
  parameter int NUM_DATA     = 2,
  parameter int RD_W         = 5,
  parameter int CTRL_W       = 2,
  parameter int SKID         = 1,
  parameter int SUPPRESS_RD0 = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic                       i_flush,
  input  logic [CTRL_W-1:0]          i_ctrl,
  input  logic [RD_W-1:0]            i_rd,
  input  logic [NUM_DATA*DATA_W-1:0] i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [CTRL_W-1:0]          o_ctrl,
  output logic [RD_W-1:0]            o_rd,
  output logic [NUM_DATA*DATA_W-1:0] o_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                     state, state_next;
  logic [CTRL_W-1:0]          head_ctrl, skid_ctrl, cap_ctrl;
  logic [RD_W-1:0]            head_rd, skid_rd;
  logic [NUM_DATA*DATA_W-1:0] head_data, skid_data;
  logic                       accept, retire;
  logic                       load_head_in, load_head_skid, load_skid;

  // A write to x0 is dropped here so that WB never has to special-case it.
  always_comb begin
    cap_ctrl = i_ctrl;
    if (SUPPRESS_RD0 != 0 && i_rd == '0) cap_ctrl[0] = 1'b0;
  end

  assign o_valid = (state != EMPTY);
  assign o_ready = !i_reset && ((SKID != 0) ? (state != TWO) : (!o_valid || i_ready));
  assign accept  = i_valid && o_ready && !i_flush;
  assign retire  = o_valid && i_ready;

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && retire) begin
          load_head_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (retire) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (retire) begin
          state_next     = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
    // On a flush every held entry is dropped. A retire in the same cycle has already completed downstream.
    if (i_flush) begin
      state_next     = EMPTY;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= EMPTY;
      head_ctrl <= '0;
      head_rd   <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_rd   <= '0;
      skid_data <= '0;
    end else begin
      state <= state_next;
      if (load_head_in) begin
        head_ctrl <= cap_ctrl;
        head_rd   <= i_rd;
        head_data <= i_data;
      end else if (load_head_skid) begin
        head_ctrl <= skid_ctrl;
        head_rd   <= skid_rd;
        head_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= cap_ctrl;
        skid_rd   <= i_rd;
        skid_data <= i_data;
      end
    end
  end

  // A bubble must never carry a live write-enable.
  assign o_ctrl = o_valid ? head_ctrl : '0;
  assign o_rd   = head_rd;
  assign o_data = head_data;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage with a queue scoreboard.
// One instance uses the skid entry with x0 suppression; the other uses a single entry with no suppression.
module tb_wb_pipe_stage;

  localparam int DW = 32;
  localparam int ND = 2;
  localparam int RW = 5;
  localparam int CW = 2;
  localparam int PW = ND * DW;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rd;
    logic [PW-1:0] data;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          s_valid, s_flush, s_rdy, s_o_ready, s_o_valid;
  logic [CW-1:0] s_ctrl, s_o_ctrl;
  logic [RW-1:0] s_rd, s_o_rd;
  logic [PW-1:0] s_data, s_o_data;
  logic          n_valid, n_flush, n_rdy, n_o_ready, n_o_valid;
  logic [CW-1:0] n_ctrl, n_o_ctrl;
  logic [RW-1:0] n_rd, n_o_rd;
  logic [PW-1:0] n_data, n_o_data;

  wb_pipe_stage #(.DATA_W(DW), .NUM_DATA(ND), .RD_W(RW), .CTRL_W(CW), .SKID(1), .SUPPRESS_RD0(1)) dut_skid (
    .i_clk(clk), .i_reset(rst), .i_valid(s_valid), .o_ready(s_o_ready), .i_flush(s_flush),
    .i_ctrl(s_ctrl), .i_rd(s_rd), .i_data(s_data), .o_valid(s_o_valid), .i_ready(s_rdy),
    .o_ctrl(s_o_ctrl), .o_rd(s_o_rd), .o_data(s_o_data)
  );

  wb_pipe_stage #(.DATA_W(DW), .NUM_DATA(ND), .RD_W(RW), .CTRL_W(CW), .SKID(0), .SUPPRESS_RD0(0)) dut_noskid (
    .i_clk(clk), .i_reset(rst), .i_valid(n_valid), .o_ready(n_o_ready), .i_flush(n_flush),
    .i_ctrl(n_ctrl), .i_rd(n_rd), .i_data(n_data), .o_valid(n_o_valid), .i_ready(n_rdy),
    .o_ctrl(n_o_ctrl), .o_rd(n_o_rd), .o_data(n_o_data)
  );

  entry_t q_s[$];
  entry_t q_n[$];
  entry_t last_s, last_n;
  int     assert_count = 0;
  int     fail_count = 0;
  int     ret_s = 0;
  int     ret_n = 0;
  bit     acc_s, acc_n;
  int     idx;

  function automatic entry_t mk(logic [CW-1:0] c, logic [RW-1:0] r, logic [PW-1:0] d, bit sup);
    entry_t e;
    e.ctrl = c;
    e.rd   = r;
    e.data = d;
    if (sup && r == '0) e.ctrl[0] = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(string tag, logic [PW-1:0] obs, logic [PW-1:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(bit skid_side, logic v, logic [CW-1:0] c, logic [RW-1:0] r,
                               logic [PW-1:0] d, logic rdy, logic fl);
    if (skid_side) begin
      s_valid = v; s_ctrl = c; s_rd = r; s_data = d; s_rdy = rdy; s_flush = fl;
    end else begin
      n_valid = v; n_ctrl = c; n_rd = r; n_data = d; n_rdy = rdy; n_flush = fl;
    end
  endtask

  // Check both instances against the models, cross one edge, then advance the models.
  task automatic tick();
    logic   er_s, er_n;
    entry_t hs, hn;
    #1;
    er_s = !rst && (q_s.size() < 2);
    er_n = !rst && (q_n.size() == 0 || n_rdy);
    if (q_s.size() > 0) last_s = q_s[0];
    if (q_n.size() > 0) last_n = q_n[0];
    hs = last_s;
    hn = last_n;
    checkOutput("skid_ready", PW'(s_o_ready), PW'(er_s));
    checkOutput("skid_valid", PW'(s_o_valid), PW'(q_s.size() > 0));
    checkOutput("skid_ctrl", PW'(s_o_ctrl), (q_s.size() > 0) ? PW'(hs.ctrl) : '0);
    checkOutput("skid_rd", PW'(s_o_rd), PW'(hs.rd));
    checkOutput("skid_data", s_o_data, hs.data);
    checkOutput("noskid_ready", PW'(n_o_ready), PW'(er_n));
    checkOutput("noskid_valid", PW'(n_o_valid), PW'(q_n.size() > 0));
    checkOutput("noskid_ctrl", PW'(n_o_ctrl), (q_n.size() > 0) ? PW'(hn.ctrl) : '0);
    checkOutput("noskid_rd", PW'(n_o_rd), PW'(hn.rd));
    checkOutput("noskid_data", n_o_data, hn.data);
    if (!rst && s_o_valid === 1'b1 && s_rdy) ret_s++;
    if (!rst && n_o_valid === 1'b1 && n_rdy) ret_n++;
    @(posedge clk);
    if (rst) begin
      q_s.delete(); q_n.delete();
      last_s = '0; last_n = '0;
      acc_s = 1'b0; acc_n = 1'b0;
    end else begin
      acc_s = s_valid && er_s && !s_flush;
      if (q_s.size() > 0 && s_rdy) void'(q_s.pop_front());
      if (s_flush) q_s.delete();
      else if (acc_s) q_s.push_back(mk(s_ctrl, s_rd, s_data, 1'b1));
      acc_n = n_valid && er_n && !n_flush;
      if (q_n.size() > 0 && n_rdy) void'(q_n.pop_front());
      if (n_flush) q_n.delete();
      else if (acc_n) q_n.push_back(mk(n_ctrl, n_rd, n_data, 1'b0));
    end
    #1;
  endtask

  initial begin
    last_s = '0; last_n = '0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd1, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 5'd1, 64'h1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    $display("[TB] reset held with valid high");
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    tick();

    $display("[TB] streaming on skid instance");
    idx = 0;
    for (int c = 0; c < 30 && (idx < 8 || q_s.size() > 0); c++) begin
      applyStimulus(1'b1, idx < 8, 2'b01, RW'(idx + 1), {32'hA000_0000 + 32'(idx), 32'h10 + 32'(idx)}, 1'b1, 1'b0);
      tick();
      if (acc_s) idx++;
    end
    checkOutput("stream_accepted", PW'(idx), PW'(8));

    $display("[TB] stall with A, B, C");
    idx = 0;
    for (int c = 0; c < 30 && (idx < 3 || q_s.size() > 0); c++) begin
      applyStimulus(1'b1, idx < 3, 2'b01, RW'(20 + idx), {32'h0, 32'hA + 32'(idx)}, c >= 4, 1'b0);
      tick();
      if (acc_s) idx++;
    end
    checkOutput("stall_accepted", PW'(idx), PW'(3));

    $display("[TB] rd0 suppression");
    applyStimulus(1'b1, 1'b1, 2'b11, 5'd0, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b11, 5'd0, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    tick();
    tick();

    $display("[TB] flush with two entries held");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd7, 64'hD, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd8, 64'hE, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd9, 64'hF, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 64'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    tick();

    $display("[TB] single-entry back-pressure");
    idx = 0;
    for (int c = 0; c < 40 && (idx < 8 || q_n.size() > 0); c++) begin
      applyStimulus(1'b0, idx < 8, 2'b01, RW'(idx + 3), {32'h5000_0000 + 32'(idx), 32'h20 + 32'(idx)}, (c % 2) == 0, 1'b0);
      tick();
      if (acc_n) idx++;
    end
    checkOutput("bp_accepted", PW'(idx), PW'(8));
    applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    tick();

    $display("[TB] reset during stall with two entries");
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd11, 64'h11, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 2'b01, 5'd12, 64'h12, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 64'h0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 5'd0, 64'h0, 1'b1, 1'b0);
    tick();

    checkOutput("skid_retired", PW'(ret_s), PW'(12));
    checkOutput("noskid_retired", PW'(ret_n), PW'(9));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised, handshaked pipeline stage register that replaces the fixed MEM→WB register. It carries a control bundle, destination register index and N data words with valid/ready flow control, supports flush (bubble insertion) and an optional skid entry that cuts the combinational ready path. It also suppresses register-file writes to rd = 0. It sits between the MEM and WB stages but is generic enough for any stage boundary.

## Interface
Parameters:
- DATA_W, 32, width of one data word
- NUM_DATA, 2, number of data words carried (e.g. ALU result, dmem read data)
- RD_W, 5, destination register index width
- CTRL_W, 2, control bundle width; bit 0 is the write-enable (wreg)
- SKID, 1, 1 = two-entry skid stage with registered o_ready; 0 = single entry with combinational o_ready
- SUPPRESS_RD0, 1, 1 = force ctrl bit 0 to 0 at capture when rd == 0

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  reset; synchronous, active-high
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept this cycle
- i_flush  in  1  discard all held entries and any entry offered this cycle
- i_ctrl  in  CTRL_W  control bundle
- i_rd  in  RD_W  destination register
- i_data  in  NUM_DATA*DATA_W  data words; word k is bits [k*DATA_W +: DATA_W]
- o_valid  out  1  downstream entry valid
- i_ready  in  1  downstream accepts
- o_ctrl  out  CTRL_W  control of the head entry; all zero when o_valid = 0
- o_rd  out  RD_W  rd of the head entry
- o_data  out  NUM_DATA*DATA_W  data of the head entry

## Operation
- Handshake semantics:
  - Accept: i_valid & o_ready & !i_flush.
  - Retire: o_valid & i_ready.
  - Downstream payload is held stable while o_valid & !i_ready.
- Capture transform: when SUPPRESS_RD0 = 1 and i_rd == 0, ctrl bit 0 is stored as 0. All other bits are stored unchanged.
- SKID = 1 uses states EMPTY, ONE (head valid) and TWO (head and skid valid).
  - EMPTY: accept → ONE.
  - ONE:
    - accept & retire → ONE (the new entry becomes head).
    - accept & !retire → TWO (the new entry goes to skid).
    - retire & !accept → EMPTY.
  - TWO:
    - retire → ONE (skid moves to head). No accept is possible in this state.
  - o_ready = (state != TWO). o_ready is a function of registered state only.
- SKID = 0 uses states EMPTY and ONE.
  - o_ready = !o_valid | i_ready (combinational).
  - Accept & retire in the same cycle replaces the head.
- Flush: in the cycle i_flush = 1 the next state is EMPTY, regardless of accept or retire.
  - A retire occurring in the flush cycle still completes downstream.
- Reset: next state is EMPTY. The payload registers are cleared to 0.
  - o_ready = 0 while i_reset = 1. Inputs are ignored in that cycle.
- Invalid head: o_ctrl is forced to 0 so that a bubble can never write the register file. o_rd and o_data keep their last values.
- Ordering: entries retire strictly in acceptance order. No entry is duplicated or dropped except by flush.

## Timing
- Latency: an entry accepted at edge t is presented on o_valid/o_* after edge t, i.e. a 1-cycle latency.
- Throughput: 1 entry per cycle when i_ready = 1 is held, in both SKID modes.
- SKID = 1 recovery: after downstream stalls for ≥2 cycles, o_ready deasserts the cycle after the skid fills. o_ready reasserts the cycle after the first retire.
- Reset values, valid one edge after i_reset is sampled high:
  - o_valid = 0
  - o_ctrl = 0
  - o_rd = 0
  - o_data = 0
- o_ready is 1 from the first cycle after reset deasserts.
- Simultaneous events:
  - Flush dominates accept.
  - Reset dominates flush.
  - Accept & retire in state ONE keeps occupancy unchanged.
- Reset asserted mid-stall with TWO entries held: both entries are lost and the stage returns to EMPTY next cycle.

## Test plan
- Reset check: assert i_reset for 2 cycles with i_valid = 1.
  - Required: o_ready = 0 during reset.
  - Required: after release, o_valid = 0, o_ctrl = 0, o_data = 0, o_ready = 1.
- Streaming (SKID = 1, i_ready = 1): send 8 entries with data word0 = 0x10+i, rd = i+1.
  - Required: o_valid rises 1 cycle after the first accept.
  - Required: 8 consecutive outputs in order, no gaps.
- Stall (SKID = 1): i_ready = 0 for 4 cycles while i_valid = 1 is held, entries A, B, C offered.
  - Required: A is held at head and B goes to skid.
  - Required: o_ready = 0 from the cycle after B is accepted.
  - Required: on release, A then B then C retire with C never lost.
- rd0 suppression: entry with rd = 0, ctrl = 2'b11, data 0xDEADBEEF.
  - Required: output ctrl = 2'b10 with data intact.
  - Required: with SUPPRESS_RD0 = 0, ctrl = 2'b11.
- Flush: hold two entries in TWO, then pulse i_flush together with a new i_valid entry.
  - Required: o_valid = 0 and o_ctrl = 0 the next cycle.
  - Required: the new entry is not accepted, and o_ready = 1.
- SKID = 0 back-pressure: i_ready toggles 1,0,1,0 while streaming.
  - Required: o_ready tracks !o_valid | i_ready combinationally.
  - Required: no entry is dropped or duplicated.
